// File: rtl/rram_array_sequencer.sv
// Drive-signal sequencer for one RRAM crossbar training pass (WLON/INIT/FF/ERR/UPD/RELAX/DONE).
// Define RRAM_SEQ_REINIT_EN to run INIT on every pass; otherwise INIT runs only until the first completed pass.
module rram_array_sequencer #(
  parameter int ROWS       = 6,
  parameter int COLS       = 6,
  parameter int PHASE_CYC  = 10,
  parameter int UPD_STRIDE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [ROWS-1:0] sl_mask,
  input  logic            label_in,
  output logic [ROWS-1:0] wl,
  output logic [ROWS-1:0] sl,
  output logic [COLS-1:0] bl,
  output logic            set,
  output logic            back,
  output logic            label,
  output logic            busy,
  output logic            done,
  output logic [2:0]      phase
);

  localparam int S   = COLS / UPD_STRIDE + 1;
  localparam int PCW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam int SW  = $clog2(S + 1);

`ifdef RRAM_SEQ_REINIT_EN
  localparam bit REINIT = 1'b1;
`else
  localparam bit REINIT = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WLON  = 3'd1,
    INIT  = 3'd2,
    FF    = 3'd3,
    ERR   = 3'd4,
    UPD   = 3'd5,
    RELAX = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t          state, nstate;
  logic [PCW-1:0]  cnt, ncnt;
  logic [SW-1:0]   sub, nsub;
  logic            init_done;
  logic            last;
  logic            skip_init;
  logic [ROWS-1:0] sl_lat;
  logic            label_lat;

  // Sub-step k lights the low k*UPD_STRIDE bitlines; the final sub-step releases them all.
  function automatic logic [COLS-1:0] upd_bl(input int k);
    logic [COLS-1:0] m;
    for (int i = 0; i < COLS; i++) m[i] = (k < S) && (i < k * UPD_STRIDE);
    return m;
  endfunction

  assign skip_init = !REINIT && init_done;

  always_comb begin
    nstate = state;
    nsub   = sub;
    ncnt   = cnt + PCW'(1);
    last   = (cnt == PCW'(PHASE_CYC - 1));
    case (state)
      IDLE:  if (start) nstate = WLON;
      WLON:  if (last) nstate = skip_init ? FF : INIT;
      INIT:  if (last) nstate = FF;
      FF:    if (last) nstate = ERR;
      ERR:   if (last) begin
               nstate = UPD;
               nsub   = SW'(1);
             end
      UPD:   if (last) begin
               if (sub == SW'(S)) begin
                 nstate = RELAX;
                 nsub   = '0;
               end else begin
                 nsub = sub + SW'(1);
               end
             end
      RELAX: if (last) nstate = DONE;
      DONE:  nstate = IDLE;
    endcase
    if (last || state == IDLE || state == DONE) ncnt = '0;
    if (abort) begin
      nstate = IDLE;
      ncnt   = '0;
      nsub   = '0;
    end
  end

  // Pass parameters are captured once per accepted start; mid-pass input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && start && !abort) begin
      sl_lat    <= sl_mask;
      label_lat <= label_in;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sub       <= '0;
      init_done <= 1'b0;
      wl        <= '0;
      sl        <= '0;
      bl        <= '0;
      set       <= 1'b0;
      back      <= 1'b0;
      label     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      phase     <= 3'd0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      sub   <= nsub;
      if (nstate == DONE) init_done <= 1'b1;
      wl    <= (nstate != IDLE && nstate != DONE) ? '1 : '0;
      sl    <= (nstate == FF || nstate == ERR || nstate == UPD || nstate == RELAX) ? sl_lat : '0;
      bl    <= (nstate == INIT) ? '1 : (nstate == UPD) ? upd_bl(int'(nsub)) : '0;
      set   <= (nstate == INIT);
      back  <= (nstate == UPD);
      label <= (nstate == ERR || nstate == UPD || nstate == RELAX) ? label_lat : 1'b0;
      busy  <= (nstate != IDLE);
      done  <= (nstate == DONE);
      phase <= nstate;
    end
  end

endmodule

// File: tb/tb_rram_array_sequencer.sv
// Randomized self-checking bench for rram_array_sequencer against a per-cycle trace model.
module tb_rram_array_sequencer;

  localparam int ROWS = 6;
  localparam int COLS = 6;
  localparam int PC   = 10;
  localparam int ST   = 2;
  localparam int S    = COLS / ST + 1;
  localparam int VW   = 8 + 2 * ROWS + COLS;

`ifdef RRAM_SEQ_REINIT_EN
  localparam bit REINIT = 1'b1;
`else
  localparam bit REINIT = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [ROWS-1:0] sl_mask;
  logic            label_in;
  logic [ROWS-1:0] wl;
  logic [ROWS-1:0] sl;
  logic [COLS-1:0] bl;
  logic            set;
  logic            back;
  logic            label;
  logic            busy;
  logic            done;
  logic [2:0]      phase;

  logic       start_s;
  logic       abort_s;
  logic [3:0] sl_mask_s;
  logic       label_s;
  logic [3:0] wl_s;
  logic [3:0] sl_s;
  logic [7:0] bl_s;
  logic       set_s;
  logic       back_s;
  logic       label_o_s;
  logic       busy_s;
  logic       done_s;
  logic [2:0] phase_s;

  int errors = 0;
  int checks = 0;
  bit inited = 0;

  typedef logic [VW-1:0] vec_t;
  vec_t exp_q[$];
  logic [VW-1:0] obs;

  assign obs = {phase, busy, done, set, back, label, wl, sl, bl};

  rram_array_sequencer #(.ROWS(ROWS), .COLS(COLS), .PHASE_CYC(PC), .UPD_STRIDE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sl_mask(sl_mask),
    .label_in(label_in), .wl(wl), .sl(sl), .bl(bl), .set(set), .back(back),
    .label(label), .busy(busy), .done(done), .phase(phase)
  );

  rram_array_sequencer #(.ROWS(4), .COLS(8), .PHASE_CYC(1), .UPD_STRIDE(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s), .sl_mask(sl_mask_s),
    .label_in(label_s), .wl(wl_s), .sl(sl_s), .bl(bl_s), .set(set_s), .back(back_s),
    .label(label_o_s), .busy(busy_s), .done(done_s), .phase(phase_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit need_init();
    return REINIT || !inited;
  endfunction

  function automatic vec_t mk(input int ph, input bit w, input bit st, input bit bk, input bit lb,
                              input logic [ROWS-1:0] s, input logic [COLS-1:0] b, input bit dn);
    logic [ROWS-1:0] wv;
    wv = w ? {ROWS{1'b1}} : {ROWS{1'b0}};
    return {3'(ph), (ph != 0), dn, st, bk, lb, wv, s, b};
  endfunction

  // Expected per-cycle outputs of one pass, straight from the phase table and durations.
  task automatic build_pass(input bit do_init, input logic [ROWS-1:0] m, input logic lab);
    logic [COLS-1:0] bv;
    exp_q.delete();
    for (int c = 0; c < PC; c++) exp_q.push_back(mk(1, 1, 0, 0, 0, '0, '0, 0));
    if (do_init)
      for (int c = 0; c < PC; c++) exp_q.push_back(mk(2, 1, 1, 0, 0, '0, '1, 0));
    for (int c = 0; c < PC; c++) exp_q.push_back(mk(3, 1, 0, 0, 0, m, '0, 0));
    for (int c = 0; c < PC; c++) exp_q.push_back(mk(4, 1, 0, 0, lab, m, '0, 0));
    for (int k = 1; k <= S; k++) begin
      bv = '0;
      if (k < S) for (int i = 0; i < k * ST; i++) bv[i] = 1'b1;
      for (int c = 0; c < PC; c++) exp_q.push_back(mk(5, 1, 0, 1, lab, m, bv, 0));
    end
    for (int c = 0; c < PC; c++) exp_q.push_back(mk(6, 1, 0, 0, lab, m, '0, 0));
    exp_q.push_back(mk(7, 0, 0, 0, 0, '0, '0, 1));
  endtask

  task automatic run_pass(input string nm, input bit do_init, input logic [ROWS-1:0] m,
                          input logic lab, input int abort_at, input bit hold);
    int done_at;
    int exp_len;
    done_at = -1;
    exp_len = ((do_init ? 5 : 4) + S) * PC + 1;
    build_pass(do_init, m, lab);
    @(negedge clk);
    start = 1'b1; sl_mask = m; label_in = lab; abort = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (hold) begin
        sl_mask  = ROWS'($urandom);
        label_in = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", nm, i, obs, exp_q[i]);
      end
      if (done === 1'b1 && done_at < 0) done_at = i + 1;
      if (i == abort_at) begin
        abort = 1'b1;
        start = 1'b0;
        break;
      end
    end
    if (abort_at >= 0) begin
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL %s_abort_clear: got %h expected 0", nm, obs);
      end
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s_abort_nodone: got done=%b busy=%b expected 0 0", nm, done, busy);
        end
      end
      return;
    end
    checks++;
    if (done_at !== exp_len) begin
      errors++;
      $display("FAIL %s_done_cycle: got %0d expected %0d", nm, done_at, exp_len);
    end
    inited = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL %s_idle_after: got %h expected 0", nm, obs);
    end
    if (hold) begin
      @(negedge clk);
      checks++;
      if (phase !== 3'd1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_restart: got phase=%0d busy=%b expected 1 1", nm, phase, busy);
      end
      start = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL %s_cleanup: got %h expected 0", nm, obs);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    inited = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_value: got %h expected 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected 0", obs);
    end
  endtask

  task automatic test_first_pass();
    run_pass("first_pass", need_init(), 6'b110000, 1'b1, -1, 1'b0);
  endtask

  task automatic test_second_pass();
    for (int p = 0; p < 2; p++)
      run_pass("repeat_pass", need_init(), ROWS'($urandom), 1'($urandom), -1, 1'b0);
  endtask

  task automatic test_abort();
    do_reset();
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || phase !== 3'd0) begin
      errors++;
      $display("FAIL abort_beats_start: got busy=%b phase=%0d expected 0 0", busy, phase);
    end
    run_pass("abort_upd2", need_init(), ROWS'($urandom), 1'b1, 40 + PC + $urandom_range(0, PC - 1), 1'b0);
    run_pass("after_abort", need_init(), ROWS'($urandom), 1'($urandom), -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_pass("held_start", need_init(), ROWS'($urandom), 1'($urandom), -1, 1'b1);
  endtask

  task automatic test_reset_midpass();
    int at;
    at = need_init() ? 25 : 15;
    @(negedge clk);
    start = 1'b1; sl_mask = ROWS'($urandom); label_in = 1'b1;
    for (int i = 0; i <= at; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (phase !== 3'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midpass_state: got phase=%0d busy=%b expected 3 1", phase, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    inited = 1'b0;
    run_pass("post_reset", need_init(), ROWS'($urandom), 1'($urandom), -1, 1'b0);
  endtask

  task automatic test_small_config();
    int         ph_e[9];
    logic [7:0] bl_e[9];
    int         done_at;
    ph_e = '{1, 2, 3, 4, 5, 5, 5, 6, 7};
    bl_e = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h00};
    done_at = -1;
    @(negedge clk);
    start_s = 1'b1; sl_mask_s = 4'($urandom); label_s = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      start_s = 1'b0;
      checks++;
      if (phase_s !== 3'(ph_e[i]) || bl_s !== bl_e[i] || busy_s !== 1'b1) begin
        errors++;
        $display("FAIL small_cfg cycle %0d: got phase=%0d bl=%b busy=%b expected %0d %b 1",
                 i, phase_s, bl_s, busy_s, ph_e[i], bl_e[i]);
      end
      if (done_s === 1'b1 && done_at < 0) done_at = i + 1;
    end
    checks++;
    if (done_at !== 9) begin
      errors++;
      $display("FAIL small_done_cycle: got %0d expected 9", done_at);
    end
    @(negedge clk);
    checks++;
    if (busy_s !== 1'b0 || phase_s !== 3'd0) begin
      errors++;
      $display("FAIL small_idle: got busy=%b phase=%0d expected 0 0", busy_s, phase_s);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sl_mask = '0; label_in = 1'b0;
    start_s = 1'b0; abort_s = 1'b0; sl_mask_s = '0; label_s = 1'b0;
    test_reset();
    test_first_pass();
    test_second_pass();
    test_abort();
    test_back_to_back();
    test_reset_midpass();
    test_small_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
